// File: rtl/controlador_irrigacao.sv
// rtl/controlador_irrigacao.sv - irrigation sequencer: mode select, cronometro reload, rest pause, tank fill with timeout
module controlador_irrigacao #(
    parameter int unsigned TEMPO_ENCHIMENTO = 60,
    parameter int unsigned TEMPO_PAUSA      = 10,
    parameter logic [2:0]  NIVEL_MINIMO     = 3'b001
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       umSegundo,
    input  logic       hab,
    input  logic [1:0] sensorUmidade,
    input  logic [2:0] nivelDagua,
    input  logic       tempoZerado,
    output logic       aspersao,
    output logic       gotejamento,
    output logic       valvulaEntrada,
    output logic       alarme,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        OCIOSO    = 3'b000,
        CARGA     = 3'b001,
        IRRIGANDO = 3'b010,
        ENCHENDO  = 3'b011,
        PAUSA     = 3'b100,
        FALHA     = 3'b101
    } estadoT;

    // Timeouts fire on the edge that samples the Nth pulse, so compare against N-1.
    localparam logic [7:0] LIMITE_ENCH  = 8'(TEMPO_ENCHIMENTO - 1);
    localparam logic [7:0] LIMITE_PAUSA = 8'(TEMPO_PAUSA - 1);

    estadoT     estadoAtual;
    estadoT     estadoNext;
    logic [1:0] modoReg;
    logic [1:0] modoNext;
    logic [7:0] contador;
    logic       tickVisto;
    logic [2:0] nivelDecod;
    logic       nivelOk;

    // Anything that is not a clean thermometer code is read as an empty tank.
    always_comb begin
        nivelDecod = 3'b000;
        case (nivelDagua)
            3'b001:  nivelDecod = 3'b001;
            3'b011:  nivelDecod = 3'b011;
            3'b111:  nivelDecod = 3'b111;
            default: nivelDecod = 3'b000;
        endcase
    end

    assign nivelOk = (nivelDecod >= NIVEL_MINIMO);

    // modoReg = {aspersao, gotejamento} chosen when leaving OCIOSO.
    always_comb begin
        estadoNext = estadoAtual;
        modoNext   = modoReg;
        case (estadoAtual)
            OCIOSO: begin
                if (hab) begin
                    if (!nivelOk) begin
                        estadoNext = ENCHENDO;
                    end else if (sensorUmidade == 2'b00) begin
                        modoNext   = 2'b10;
                        estadoNext = CARGA;
                    end else if (sensorUmidade == 2'b01) begin
                        modoNext   = 2'b01;
                        estadoNext = CARGA;
                    end
                end
            end
            CARGA: begin
                estadoNext = IRRIGANDO;
            end
            IRRIGANDO: begin
                if (!hab) begin
                    estadoNext = OCIOSO;
                end else if (nivelDecod == 3'b000) begin
                    estadoNext = ENCHENDO;
                end else if (tempoZerado && tickVisto) begin
                    estadoNext = PAUSA;
                end
            end
            ENCHENDO: begin
                if (!hab) begin
                    estadoNext = OCIOSO;
                end else if (nivelDecod == 3'b111) begin
                    estadoNext = PAUSA;
                end else if (umSegundo && (contador == LIMITE_ENCH)) begin
                    estadoNext = FALHA;
                end
            end
            PAUSA: begin
                if (!hab) begin
                    estadoNext = OCIOSO;
                end else if (umSegundo && (contador == LIMITE_PAUSA)) begin
                    estadoNext = OCIOSO;
                end
            end
            FALHA: begin
                if (!hab) begin
                    estadoNext = OCIOSO;
                end
            end
            default: begin
                estadoNext = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estadoAtual <= OCIOSO;
            modoReg     <= 2'b00;
            contador    <= 8'd0;
            tickVisto   <= 1'b0;
        end else begin
            estadoAtual <= estadoNext;
            modoReg     <= modoNext;
            // A pulse on the entry edge belongs to the state being left.
            if (estadoNext != estadoAtual) begin
                contador  <= 8'd0;
                tickVisto <= 1'b0;
            end else if (umSegundo) begin
                if (contador != 8'hFF) begin
                    contador <= contador + 8'd1;
                end
                tickVisto <= 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so they change on the same edge as estado.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aspersao       <= 1'b0;
            gotejamento    <= 1'b0;
            valvulaEntrada <= 1'b0;
            alarme         <= 1'b0;
        end else begin
            aspersao       <= (estadoNext == IRRIGANDO) && modoNext[1];
            gotejamento    <= (estadoNext == IRRIGANDO) && modoNext[0] && !modoNext[1];
            valvulaEntrada <= (estadoNext == ENCHENDO);
            alarme         <= (estadoNext == FALHA);
        end
    end

    assign estado = estadoAtual;

endmodule

// File: tb/tb_controlador_irrigacao.sv
// tb/tb_controlador_irrigacao.sv - directed and randomized checks of controlador_irrigacao against a behavioural model
module tb_controlador_irrigacao;

    localparam int TE = 60;
    localparam int TP = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       umSegundo = 1'b0;
    logic       hab = 1'b0;
    logic [1:0] sensorUmidade = 2'b00;
    logic [2:0] nivelDagua = 3'b000;
    logic       tempoZerado = 1'b0;
    logic       aspersao;
    logic       gotejamento;
    logic       valvulaEntrada;
    logic       alarme;
    logic [2:0] estado;

    int nComparados = 0;
    int nDivergentes = 0;

    // Model: phase number, seconds spent in phase, chosen mode (1 sprinkler, 2 drip), tick seen.
    int mEstado = 0;
    int mSegundos = 0;
    int mModo = 0;
    bit mVisto = 1'b0;

    controlador_irrigacao dut (
        .clock         (clock),
        .reset         (reset),
        .umSegundo     (umSegundo),
        .hab           (hab),
        .sensorUmidade (sensorUmidade),
        .nivelDagua    (nivelDagua),
        .tempoZerado   (tempoZerado),
        .aspersao      (aspersao),
        .gotejamento   (gotejamento),
        .valvulaEntrada(valvulaEntrada),
        .alarme        (alarme),
        .estado        (estado)
    );

    always #5 clock = ~clock;

    task automatic verificar(input string tag, input int observado, input int esperado);
        nComparados++;
        if (observado != esperado) begin
            nDivergentes++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, observado, esperado, $time);
        end
    endtask

    task automatic modeloReset();
        mEstado = 0;
        mSegundos = 0;
        mModo = 0;
        mVisto = 1'b0;
    endtask

    // Called once per rising edge with the inputs that edge sampled.
    task automatic modeloPasso();
        int lvl;
        int nxt;
        int nivel;
        nivel = int'(nivelDagua);
        lvl = (nivel == 1 || nivel == 3 || nivel == 7) ? nivel : 0;
        nxt = mEstado;
        if (mEstado == 0) begin
            if (hab && lvl < 1) nxt = 3;
            else if (hab && sensorUmidade == 2'd0) begin mModo = 1; nxt = 1; end
            else if (hab && sensorUmidade == 2'd1) begin mModo = 2; nxt = 1; end
        end else if (mEstado == 1) begin
            nxt = 2;
        end else if (mEstado == 2) begin
            if (!hab) nxt = 0;
            else if (lvl == 0) nxt = 3;
            else if (tempoZerado && mVisto) nxt = 4;
        end else if (mEstado == 3) begin
            if (!hab) nxt = 0;
            else if (lvl == 7) nxt = 4;
            else if (umSegundo && mSegundos + 1 >= TE) nxt = 5;
        end else if (mEstado == 4) begin
            if (!hab) nxt = 0;
            else if (umSegundo && mSegundos + 1 >= TP) nxt = 0;
        end else if (mEstado == 5) begin
            if (!hab) nxt = 0;
        end
        if (nxt != mEstado) begin
            mSegundos = 0;
            mVisto = 1'b0;
        end else if (umSegundo) begin
            mSegundos++;
            mVisto = 1'b1;
        end
        mEstado = nxt;
    endtask

    task automatic conferirSaidas(input string tag);
        verificar({tag, "/estado"}, int'(estado), mEstado);
        verificar({tag, "/aspersao"}, int'(aspersao), (mEstado == 2 && mModo == 1) ? 1 : 0);
        verificar({tag, "/gotejamento"}, int'(gotejamento), (mEstado == 2 && mModo == 2) ? 1 : 0);
        verificar({tag, "/valvula"}, int'(valvulaEntrada), (mEstado == 3) ? 1 : 0);
        verificar({tag, "/alarme"}, int'(alarme), (mEstado == 5) ? 1 : 0);
    endtask

    task automatic ciclo(input bit h, input bit [1:0] s, input bit [2:0] n, input bit z, input bit t,
                         input string tag);
        @(negedge clock);
        hab = h;
        sensorUmidade = s;
        nivelDagua = n;
        tempoZerado = z;
        umSegundo = t;
        @(posedge clock);
        modeloPasso();
        #1;
        conferirSaidas(tag);
    endtask

    // Entered at posedge+1; asserts reset between edges and holds it across one edge.
    task automatic resetAssincrono(input string tag);
        #2;
        reset = 1'b0;
        modeloReset();
        #1;
        verificar({tag, "/valvula_async"}, int'(valvulaEntrada), 0);
        verificar({tag, "/estado_async"}, int'(estado), 0);
        @(posedge clock);
        #1;
        conferirSaidas({tag, "/held"});
        #2;
        reset = 1'b1;
    endtask

    initial begin
        bit h;
        bit z;
        bit [1:0] s;
        bit [2:0] n;

        // Reset state
        modeloReset();
        @(posedge clock);
        #1;
        conferirSaidas("reset");
        #2;
        reset = 1'b1;

        // 1: dry soil, full tank -> CARGA then sprinkler
        ciclo(1, 2'b00, 3'b111, 0, 0, "t1_n1");
        verificar("t1_carga_estado", int'(estado), 1);
        verificar("t1_carga_asp", int'(aspersao), 0);
        ciclo(1, 2'b00, 3'b111, 1, 0, "t1_n2");
        verificar("t1_asp", int'(aspersao), 1);

        // 2: stale zero ignored until first tick, then rest pause of TP ticks
        for (int i = 0; i < 3; i++) ciclo(1, 2'b00, 3'b111, 1, 0, "t2_stale");
        verificar("t2_still_irrig", int'(estado), 2);
        ciclo(1, 2'b00, 3'b111, 1, 1, "t2_tick");
        ciclo(1, 2'b00, 3'b111, 1, 0, "t2_zero");
        verificar("t2_pausa", int'(estado), 4);
        for (int i = 0; i < TP; i++) begin
            ciclo(1, 2'b10, 3'b111, 0, 1, "t2_rest_tick");
            if (i < TP - 1) ciclo(1, 2'b10, 3'b111, 0, 0, "t2_rest");
        end
        verificar("t2_ocioso", int'(estado), 0);

        // 3: drip at mid level, tank empties mid-irrigation, then refills
        ciclo(1, 2'b01, 3'b011, 0, 0, "t3_carga");
        ciclo(1, 2'b01, 3'b011, 0, 0, "t3_irrig");
        verificar("t3_got", int'(gotejamento), 1);
        ciclo(1, 2'b01, 3'b000, 0, 0, "t3_empty");
        verificar("t3_got_drop", int'(gotejamento), 0);
        verificar("t3_valve", int'(valvulaEntrada), 1);
        ciclo(1, 2'b01, 3'b111, 0, 0, "t3_full");
        verificar("t3_pausa", int'(estado), 4);
        ciclo(0, 2'b01, 3'b111, 0, 0, "t3_off");

        // 4: non-thermometer level never fills -> FALHA after TE ticks
        ciclo(1, 2'b00, 3'b010, 0, 1, "t4_enter");
        verificar("t4_enchendo", int'(estado), 3);
        for (int i = 0; i < TE; i++) ciclo(1, 2'b00, 3'b010, 0, 1, "t4_fill");
        verificar("t4_falha", int'(estado), 5);
        verificar("t4_alarme", int'(alarme), 1);
        ciclo(1, 2'b01, 3'b111, 0, 1, "t4_ignore");
        ciclo(0, 2'b00, 3'b010, 0, 0, "t4_off");
        verificar("t4_alarme_clr", int'(alarme), 0);

        // 5: full and timeout together -> PAUSA; hab=0 wins in IRRIGANDO
        ciclo(1, 2'b00, 3'b000, 0, 0, "t5_enter");
        for (int i = 0; i < TE - 1; i++) ciclo(1, 2'b00, 3'b000, 0, 1, "t5_fill");
        ciclo(1, 2'b00, 3'b111, 0, 1, "t5_both");
        verificar("t5_full_wins", int'(estado), 4);
        ciclo(0, 2'b00, 3'b111, 0, 0, "t5_off");
        ciclo(1, 2'b00, 3'b111, 0, 0, "t5_carga");
        ciclo(1, 2'b00, 3'b111, 0, 1, "t5_irrig");
        ciclo(0, 2'b00, 3'b000, 1, 1, "t5_prio");
        verificar("t5_hab_wins", int'(estado), 0);

        // 6: async reset mid-fill; wet soil stays idle
        ciclo(1, 2'b00, 3'b001, 0, 0, "t6_low_ok");
        ciclo(1, 2'b00, 3'b000, 0, 0, "t6_toidle");
        ciclo(0, 2'b00, 3'b000, 0, 0, "t6_idle");
        ciclo(1, 2'b00, 3'b100, 0, 0, "t6_enter");
        ciclo(1, 2'b00, 3'b100, 0, 1, "t6_fill");
        resetAssincrono("t6_reset");
        for (int i = 0; i < 3; i++) ciclo(1, 2'b10, 3'b111, 1, 1, "t6_wet");
        verificar("t6_wet_idle", int'(estado), 0);

        // Randomized traffic
        h = 1; z = 0; s = 0; n = 3'b111;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) h = ~h;
            if ($urandom_range(0, 7) == 0) s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 40) == 0) n = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) z = ~z;
            ciclo(h, s, n, z, ($urandom_range(0, 2) == 0), "rand");
            if ($urandom_range(0, 599) == 0) resetAssincrono("rand_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComparados, nDivergentes);
        $finish;
    end

endmodule
